// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall controller: FSM states,
// forwarding-mux select codes and the drain length used when halting.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  // EX operand source select
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Unfrozen cycles spent emptying ID/EX/MEM before declaring HALTED
  localparam int         DRAIN_CYCLES = 3;
  localparam logic [1:0] DRAIN_LOAD   = 2'(DRAIN_CYCLES);

endpackage

// File: rtl/pipeline_ctrl_forward_unit.sv
// Operand forwarding select for one EX source register. MEM has priority
// over WB because it holds the younger result; x0 is never forwarded.
module forward_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] ex_rs,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_reg_write,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             wb_reg_write,
  output logic [1:0]       fwd_sel
);

  // Pick the youngest in-flight producer of ex_rs
  always_comb begin
    fwd_sel = FWD_RF;
    if (mem_reg_write && (mem_rd != '0) && (mem_rd == ex_rs)) begin
      fwd_sel = FWD_MEM;
    end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == ex_rs)) begin
      fwd_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline control: forwarding selects, load-use stall, branch
// flush, memory-wait freeze, HALT drain sequence and a saturating stall counter.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic [1:0]       id_use,
  input  logic             id_halt,
  input  logic [REG_W-1:0] ex_rs1,
  input  logic [REG_W-1:0] ex_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_reg_write,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             wb_reg_write,
  output logic             fe_en,
  output logic             pipe_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  state_t           state_reg;
  logic [1:0]       drain_cnt_reg;
  logic [CNT_W-1:0] stall_cnt_reg;

  logic freeze;
  logic load_use;
  logic run_active;
  logic run_branch;
  logic run_load_use;
  logic run_halt;
  logic stall_event;

  // Operand forwarding, one unit per EX source operand
  logic [REG_W-1:0] ex_rs   [2];
  logic [1:0]       fwd_raw [2];

  assign ex_rs[0] = ex_rs1;
  assign ex_rs[1] = ex_rs2;

  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    forward_unit #(
      .REG_W(REG_W)
    ) u_fwd (
      .ex_rs        (ex_rs[gi]),
      .mem_rd       (mem_rd),
      .mem_reg_write(mem_reg_write),
      .wb_rd        (wb_rd),
      .wb_reg_write (wb_reg_write),
      .fwd_sel      (fwd_raw[gi])
    );
  end

  // Selects are forced to the register file while reset is held
  assign fwd_a = rst ? fwd_raw[0] : FWD_RF;
  assign fwd_b = rst ? fwd_raw[1] : FWD_RF;

  // Hazard decode with priority freeze > branch > load-use > halt
  always_comb begin
    freeze       = mem_req && !mem_ready;
    load_use     = ex_mem_read && (ex_rd != '0) &&
                   ((id_use[0] && (id_rs1 == ex_rd)) ||
                    (id_use[1] && (id_rs2 == ex_rd)));
    run_active   = (state_reg == RUN) && !freeze;
    run_branch   = run_active && ex_branch_taken;
    run_load_use = run_active && !ex_branch_taken && load_use;
    run_halt     = run_active && !ex_branch_taken && !load_use && id_halt;
    stall_event  = (freeze && (state_reg != HALTED)) || run_load_use;
  end

  // Stage enables and bubble injection for the current state and hazards
  always_comb begin
    fe_en      = 1'b0;
    pipe_en    = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (rst && !freeze) begin
      case (state_reg)
        RUN: begin
          pipe_en = 1'b1;
          if (ex_branch_taken) begin
            fe_en      = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (load_use) begin
            idex_flush = 1'b1;
          end else begin
            fe_en = 1'b1;
          end
        end
        DRAIN: begin
          pipe_en    = 1'b1;
          idex_flush = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // RUN -> DRAIN -> HALTED sequencing; only reset leaves HALTED
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= RUN;
      drain_cnt_reg <= '0;
    end else begin
      case (state_reg)
        RUN: begin
          if (run_halt) begin
            state_reg     <= DRAIN;
            drain_cnt_reg <= DRAIN_LOAD;
          end
        end
        DRAIN: begin
          if (!freeze) begin
            if (drain_cnt_reg == 2'd1) begin
              state_reg     <= HALTED;
              drain_cnt_reg <= '0;
            end else begin
              drain_cnt_reg <= drain_cnt_reg - 2'd1;
            end
          end
        end
        HALTED: begin
        end
        default: begin
          state_reg     <= RUN;
          drain_cnt_reg <= '0;
        end
      endcase
    end
  end

  // Saturating count of lost cycles (load-use bubbles and memory freezes)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_reg <= '0;
    end else if (stall_event && (stall_cnt_reg != '1)) begin
      stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_reg;
  assign halted    = (state_reg == HALTED);

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: a driver applies one stimulus vector
// per cycle and queues the reference model's prediction; a monitor pops and
// compares on the falling edge.
module tb_pipeline_ctrl;

  localparam int REG_W   = 5;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [REG_W-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic [1:0]       id_use;
  logic             id_halt, ex_mem_read, ex_branch_taken;
  logic             mem_reg_write, mem_req, mem_ready, wb_reg_write;
  logic             fe_en, pipe_en, ifid_flush, idex_flush, halted;
  logic [1:0]       fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_cnt;

  always #5 clk = ~clk;

  pipeline_ctrl #(
    .REG_W(REG_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_use         (id_use),
    .id_halt        (id_halt),
    .ex_rs1         (ex_rs1),
    .ex_rs2         (ex_rs2),
    .ex_rd          (ex_rd),
    .ex_mem_read    (ex_mem_read),
    .ex_branch_taken(ex_branch_taken),
    .mem_rd         (mem_rd),
    .mem_reg_write  (mem_reg_write),
    .mem_req        (mem_req),
    .mem_ready      (mem_ready),
    .wb_rd          (wb_rd),
    .wb_reg_write   (wb_reg_write),
    .fe_en          (fe_en),
    .pipe_en        (pipe_en),
    .ifid_flush     (ifid_flush),
    .idex_flush     (idex_flush),
    .fwd_a          (fwd_a),
    .fwd_b          (fwd_b),
    .halted         (halted),
    .stall_cnt      (stall_cnt)
  );

  typedef struct {
    logic             rst;
    logic [REG_W-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic [1:0]       id_use;
    logic             id_halt, ex_mem_read, ex_branch_taken;
    logic             mem_reg_write, mem_req, mem_ready, wb_reg_write;
  } stim_t;

  typedef struct {
    string            tag;
    logic             fe, pipe, ifid, idex, halted;
    logic [1:0]       fa, fb;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t  sb_q[$];
  int    checks = 0;
  int    errors = 0;

  // Reference model state: cycles of draining left, halted flag, stall total
  int    m_drain_left = 0;
  bit    m_halted     = 1'b0;
  int    m_cnt        = 0;
  stim_t cur;

  function automatic stim_t idle();
    stim_t s;
    s.rst = 1'b1;
    s.id_rs1 = '0; s.id_rs2 = '0; s.ex_rs1 = '0; s.ex_rs2 = '0;
    s.ex_rd = '0;  s.mem_rd = '0; s.wb_rd = '0;  s.id_use = '0;
    s.id_halt = 1'b0; s.ex_mem_read = 1'b0; s.ex_branch_taken = 1'b0;
    s.mem_reg_write = 1'b0; s.mem_req = 1'b0; s.mem_ready = 1'b0;
    s.wb_reg_write = 1'b0;
    return s;
  endfunction

  function automatic logic [1:0] ref_fwd(logic [REG_W-1:0] rs, stim_t s);
    if (s.mem_reg_write && s.mem_rd != 0 && s.mem_rd == rs) return 2'b10;
    if (s.wb_reg_write && s.wb_rd != 0 && s.wb_rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit ref_lu(stim_t s);
    return s.ex_mem_read && s.ex_rd != 0 &&
           ((s.id_use[0] && s.id_rs1 == s.ex_rd) ||
            (s.id_use[1] && s.id_rs2 == s.ex_rd));
  endfunction

  function automatic void bump();
    if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
  endfunction

  // Advance the model across one rising edge using the inputs held in cur
  function automatic void model_edge();
    bit frz;
    frz = cur.mem_req && !cur.mem_ready;
    if (!cur.rst) begin
      m_drain_left = 0; m_halted = 1'b0; m_cnt = 0;
    end else if (m_halted) begin
    end else if (m_drain_left > 0) begin
      if (frz) bump();
      else begin
        m_drain_left = m_drain_left - 1;
        if (m_drain_left == 0) m_halted = 1'b1;
      end
    end else if (frz) bump();
    else if (cur.ex_branch_taken) begin
    end else if (ref_lu(cur)) bump();
    else if (cur.id_halt) m_drain_left = 3;
  endfunction

  function automatic exp_t model_out(stim_t s, string tag);
    exp_t e;
    bit   frz;
    frz = s.mem_req && !s.mem_ready;
    e.tag = tag;
    e.fe = 1'b0; e.pipe = 1'b0; e.ifid = 1'b0; e.idex = 1'b0;
    e.halted = m_halted;
    e.cnt = m_cnt[CNT_W-1:0];
    e.fa = s.rst ? ref_fwd(s.ex_rs1, s) : 2'b00;
    e.fb = s.rst ? ref_fwd(s.ex_rs2, s) : 2'b00;
    if (!s.rst || m_halted || frz) begin
    end else if (m_drain_left > 0) begin
      e.pipe = 1'b1; e.idex = 1'b1;
    end else if (s.ex_branch_taken) begin
      e.fe = 1'b1; e.pipe = 1'b1; e.ifid = 1'b1; e.idex = 1'b1;
    end else if (ref_lu(s)) begin
      e.pipe = 1'b1; e.idex = 1'b1;
    end else begin
      e.fe = 1'b1; e.pipe = 1'b1;
    end
    return e;
  endfunction

  task automatic apply(input stim_t s);
    rst = s.rst; id_rs1 = s.id_rs1; id_rs2 = s.id_rs2; id_use = s.id_use;
    id_halt = s.id_halt; ex_rs1 = s.ex_rs1; ex_rs2 = s.ex_rs2; ex_rd = s.ex_rd;
    ex_mem_read = s.ex_mem_read; ex_branch_taken = s.ex_branch_taken;
    mem_rd = s.mem_rd; mem_reg_write = s.mem_reg_write; mem_req = s.mem_req;
    mem_ready = s.mem_ready; wb_rd = s.wb_rd; wb_reg_write = s.wb_reg_write;
  endtask

  task automatic step(input stim_t s, input string tag);
    @(posedge clk);
    model_edge();
    #1;
    cur = s;
    apply(s);
    if (!s.rst) begin
      m_drain_left = 0; m_halted = 1'b0; m_cnt = 0;
    end
    sb_q.push_back(model_out(s, tag));
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: compare DUT outputs against the oldest prediction
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk({e.tag, ".fe_en"},      32'(fe_en),      32'(e.fe));
        chk({e.tag, ".pipe_en"},    32'(pipe_en),    32'(e.pipe));
        chk({e.tag, ".ifid_flush"}, 32'(ifid_flush), 32'(e.ifid));
        chk({e.tag, ".idex_flush"}, 32'(idex_flush), 32'(e.idex));
        chk({e.tag, ".fwd_a"},      32'(fwd_a),      32'(e.fa));
        chk({e.tag, ".fwd_b"},      32'(fwd_b),      32'(e.fb));
        chk({e.tag, ".halted"},     32'(halted),     32'(e.halted));
        chk({e.tag, ".stall_cnt"},  32'(stall_cnt),  32'(e.cnt));
        $display("txn %-10s fe=%b pe=%b if=%b id=%b fa=%b fb=%b h=%b cnt=%0d",
                 e.tag, fe_en, pipe_en, ifid_flush, idex_flush, fwd_a, fwd_b,
                 halted, stall_cnt);
      end
    end
  end

  // Driver: directed scenarios followed by constrained-random traffic
  initial begin
    stim_t s;
    cur = idle();
    cur.rst = 1'b0;
    apply(cur);

    s = idle(); s.rst = 1'b0;
    s.mem_rd = 5'd3; s.mem_reg_write = 1'b1; s.ex_rs1 = 5'd3;
    repeat (2) step(s, "reset");

    // Load-use on rs1, then the same pattern against x0
    s = idle(); s.ex_mem_read = 1'b1; s.ex_rd = 5'd5; s.id_rs1 = 5'd5; s.id_use = 2'b01;
    step(s, "lu");
    step(idle(), "lu_after");
    s.ex_rd = 5'd0; s.id_rs1 = 5'd0;
    step(s, "lu_x0");

    // Forwarding priority
    s = idle(); s.mem_rd = 5'd7; s.wb_rd = 5'd7; s.ex_rs1 = 5'd7; s.ex_rs2 = 5'd7;
    s.mem_reg_write = 1'b1; s.wb_reg_write = 1'b1;
    step(s, "fwd_mem");
    s.mem_reg_write = 1'b0;
    step(s, "fwd_wb");
    s.mem_reg_write = 1'b1; s.mem_rd = 5'd0; s.wb_reg_write = 1'b0;
    step(s, "fwd_rf");

    // Branch overrides load-use
    s = idle(); s.ex_branch_taken = 1'b1; s.ex_mem_read = 1'b1; s.ex_rd = 5'd9;
    s.id_rs2 = 5'd9; s.id_use = 2'b10;
    step(s, "br_lu");

    // Freeze holds a pending branch
    s = idle(); s.ex_branch_taken = 1'b1; s.mem_req = 1'b1;
    repeat (4) step(s, "frz_br");
    s.mem_ready = 1'b1;
    step(s, "thaw_br");
    step(idle(), "idle");

    // HALT with a two-cycle freeze inside the drain
    s = idle(); s.id_halt = 1'b1;
    step(s, "halt_req");
    s = idle(); s.ex_branch_taken = 1'b1; s.id_halt = 1'b1;
    step(s, "drain");
    s.mem_req = 1'b1;
    repeat (2) step(s, "drain_frz");
    s.mem_req = 1'b0;
    repeat (2) step(s, "drain");
    repeat (2) step(idle(), "halted");
    s = idle(); s.rst = 1'b0;
    step(s, "rst_halt");
    step(idle(), "after_rst");

    // Counter saturation
    s = idle(); s.mem_req = 1'b1;
    repeat (CNT_MAX + 3) step(s, "sat");
    step(idle(), "idle");

    // Random traffic with periodic resets
    for (int n = 0; n < 600; n++) begin
      s = idle();
      if (n % 80 == 79) s.rst = 1'b0;
      s.id_rs1 = 5'($urandom_range(0, 3));
      s.id_rs2 = 5'($urandom_range(0, 3));
      s.ex_rs1 = 5'($urandom_range(0, 3));
      s.ex_rs2 = 5'($urandom_range(0, 3));
      s.ex_rd  = 5'($urandom_range(0, 3));
      s.mem_rd = 5'($urandom_range(0, 3));
      s.wb_rd  = 5'($urandom_range(0, 3));
      s.id_use = 2'($urandom_range(0, 3));
      s.id_halt = ($urandom_range(0, 39) == 0);
      s.ex_mem_read = ($urandom_range(0, 2) == 0);
      s.ex_branch_taken = ($urandom_range(0, 5) == 0);
      s.mem_reg_write = 1'($urandom_range(0, 1));
      s.wb_reg_write = 1'($urandom_range(0, 1));
      s.mem_req = ($urandom_range(0, 2) == 0);
      s.mem_ready = 1'($urandom_range(0, 1));
      step(s, "rand");
    end

    @(posedge clk);
    @(posedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter REG_W, default 5: register-address width.
REQ-002 Parameter CNT_W, default 16: stall-counter width.
REQ-003 clk  in  1  rising-edge clock, single clock domain.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 id_rs1  in  REG_W  ID-stage source register 1.
REQ-006 id_rs2  in  REG_W  ID-stage source register 2.
REQ-007 id_use  in  2  bit0/bit1: ID instruction reads rs1/rs2.
REQ-008 id_halt  in  1  ID instruction is HALT.
REQ-009 ex_rs1  in  REG_W  EX-stage source register 1.
REQ-010 ex_rs2  in  REG_W  EX-stage source register 2.
REQ-011 ex_rd  in  REG_W  EX-stage destination.
REQ-012 ex_mem_read  in  1  EX instruction is a load.
REQ-013 ex_branch_taken  in  1  EX branch/jump resolved taken.
REQ-014 mem_rd  in  REG_W  MEM-stage destination.
REQ-015 mem_reg_write  in  1  MEM instruction writes the register file.
REQ-016 mem_req  in  1  MEM stage has a data-memory access in progress.
REQ-017 mem_ready  in  1  data memory completes the access this cycle.
REQ-018 wb_rd  in  REG_W  WB-stage destination.
REQ-019 wb_reg_write  in  1  WB instruction writes the register file.
REQ-020 fe_en  out  1  PC and IF/ID register enable.
REQ-021 pipe_en  out  1  ID/EX, EX/MEM, MEM/WB register enable.
REQ-022 ifid_flush  out  1  load bubble into IF/ID.
REQ-023 idex_flush  out  1  load bubble into ID/EX.
REQ-024 fwd_a  out  2  EX operand-A select: 00 regfile, 01 WB, 10 MEM.
REQ-025 fwd_b  out  2  EX operand-B select, same encoding.
REQ-026 halted  out  1  high in HALTED state.
REQ-027 stall_cnt  out  CNT_W  saturating count of stall/freeze cycles.

Function
REQ-028 fwd_a: 10 if mem_reg_write && mem_rd!=0 && mem_rd==ex_rs1; else 01 if wb_reg_write && wb_rd!=0 && wb_rd==ex_rs1; else 00. fwd_b identical on ex_rs2. Combinational, valid in every state.
REQ-029 freeze = mem_req && !mem_ready; highest priority. Effects: fe_en=0, pipe_en=0, both flushes 0. A branch or load-use seen during freeze is acted on in the first unfrozen cycle.
REQ-030 Branch (RUN, ex_branch_taken, no freeze): fe_en=1, pipe_en=1, ifid_flush=1, idex_flush=1. Overrides load-use and id_halt.
REQ-031 Load-use (RUN, no freeze/branch): ex_mem_read && ex_rd!=0 && ((id_use[0] && id_rs1==ex_rd) || (id_use[1] && id_rs2==ex_rd)). Effects: fe_en=0, pipe_en=1, idex_flush=1 for exactly one cycle.
REQ-032 Default (RUN, no event): fe_en=1, pipe_en=1, flushes 0.
REQ-033 FSM states RUN, DRAIN, HALTED. RUN->DRAIN at the edge where id_halt=1 with no freeze, branch or load-use; 2-bit drain counter loaded with 3.
REQ-034 DRAIN: fe_en=0, pipe_en=1, idex_flush=1, ifid_flush=0; ex_branch_taken and id_halt ignored; counter decrements on each unfrozen cycle; freeze holds it; DRAIN->HALTED on the edge where counter is 1 and unfrozen (exactly 3 unfrozen DRAIN cycles).
REQ-035 HALTED: fe_en=0, pipe_en=0, flushes 0, halted=1; exit only through reset.
REQ-036 stall_cnt increments by 1 on every load-use cycle and every freeze cycle in RUN or DRAIN; saturates at all-ones; never wraps.

Reset
REQ-037 rst low asynchronously forces state RUN, drain counter 0, stall_cnt 0, halted 0. Combinational outputs while rst is low: fe_en=0, pipe_en=0, flushes 0, fwd_a=fwd_b=00. Reset in DRAIN or HALTED returns to RUN on the first edge after release.

Structure
REQ-038 Package pipe_ctrl_pkg holds the state enum (RUN, DRAIN, HALTED), the forward-select encodings (FWD_RF, FWD_WB, FWD_MEM) and DRAIN_CYCLES=3.
REQ-039 Sub-module forward_unit (combinational) implements REQ-028 and is instantiated once per operand.

Verification
REQ-040 ex_mem_read=1, ex_rd=5, id_rs1=5, id_use=01 -> one cycle of fe_en=0, idex_flush=1; stall_cnt 0->1. Same stimulus with ex_rd=0 -> no stall.
REQ-041 mem_rd=wb_rd=ex_rs1=7, both write enables 1 -> fwd_a=10; mem_reg_write=0 -> fwd_a=01; mem_rd=0 with wb_reg_write=0 -> fwd_a=00.
REQ-042 Branch and load-use in the same cycle -> fe_en=1, ifid_flush=1, idex_flush=1; stall_cnt unchanged.
REQ-043 mem_req=1, mem_ready=0 for 4 cycles while ex_branch_taken=1 -> fe_en=pipe_en=0, no flush, stall_cnt +4. Cycle mem_ready=1 -> both flushes 1.
REQ-044 id_halt=1 with a 2-cycle freeze inside DRAIN -> halted rises after 5 DRAIN cycles. rst low while HALTED -> halted=0 immediately; after release, RUN with fe_en=1.
REQ-045 Drive 2^CNT_W+2 freeze cycles (CNT_W=4 build) -> stall_cnt holds at 15.
